iicmb_wb_sequencer: RTL

Hardware command sequencer sitting directly upstream of the IICMB Wishbone I2C multi-bus controller. It converts one high-level I2C transaction request (bus, 7-bit slave address, direction, byte count) into the exact series of Wishbone register accesses the controller requires: core enable, set bus, start, address, data bytes and stop. Data is streamed through valid/ready byte ports. Per-transaction status is returned from the controller's CMDR flags.

---
 rtl/iicmb_wb_sequencer_if.sv | 51 +++++
 rtl/iicmb_wb_sequencer.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/iicmb_wb_sequencer_if.sv
// Bundle between the IICMB command sequencer and its environment.
// Carries request, byte streams, status and the Wishbone master bus.
interface iicmb_wb_sequencer_if #(
  parameter int WB_ADDR_WIDTH  = 2,
  parameter int WB_DATA_WIDTH  = 8,
  parameter int I2C_ADDR_WIDTH = 7,
  parameter int LEN_WIDTH      = 8
);
  logic                      req_valid_i;
  logic                      req_ready_o;
  logic [3:0]                req_bus_i;
  logic [I2C_ADDR_WIDTH-1:0] req_addr_i;
  logic                      req_op_i;
  logic [LEN_WIDTH-1:0]      req_len_i;
  logic                      wdat_valid_i;
  logic                      wdat_ready_o;
  logic [7:0]                wdat_i;
  logic                      rdat_valid_o;
  logic                      rdat_ready_i;
  logic [7:0]                rdat_o;
  logic                      done_o;
  logic                      nak_o;
  logic                      al_o;
  logic                      err_o;
  logic                      cyc_o;
  logic                      stb_o;
  logic                      we_o;
  logic [WB_ADDR_WIDTH-1:0]  adr_o;
  logic [WB_DATA_WIDTH-1:0]  dat_o;
  logic [WB_DATA_WIDTH-1:0]  dat_i;
  logic                      ack_i;
  logic                      irq_i;

  modport master (
    input  req_valid_i, req_bus_i, req_addr_i, req_op_i, req_len_i,
    input  wdat_valid_i, wdat_i, rdat_ready_i,
    input  dat_i, ack_i, irq_i,
    output req_ready_o, wdat_ready_o, rdat_valid_o, rdat_o,
    output done_o, nak_o, al_o, err_o,
    output cyc_o, stb_o, we_o, adr_o, dat_o
  );

  modport slave (
    output req_valid_i, req_bus_i, req_addr_i, req_op_i, req_len_i,
    output wdat_valid_i, wdat_i, rdat_ready_i,
    output dat_i, ack_i, irq_i,
    input  req_ready_o, wdat_ready_o, rdat_valid_o, rdat_o,
    input  done_o, nak_o, al_o, err_o,
    input  cyc_o, stb_o, we_o, adr_o, dat_o
  );
endinterface

// File: rtl/iicmb_wb_sequencer.sv
// Turns one I2C transaction request into IICMB Wishbone register accesses.
// Ports: clk_i, rst_n_i (async low), io = request/bytes/status/Wishbone.
module iicmb_wb_sequencer #(
  parameter int WB_ADDR_WIDTH  = 2,
  parameter int WB_DATA_WIDTH  = 8,
  parameter int I2C_ADDR_WIDTH = 7,
  parameter int LEN_WIDTH      = 8
) (
  input  logic clk_i,
  input  logic rst_n_i,
  iicmb_wb_sequencer_if.master io
);
  localparam int AW = WB_ADDR_WIDTH;
  localparam int DW = WB_DATA_WIDTH;
  localparam int LW = LEN_WIDTH;

  localparam logic [AW-1:0] A_CSR  = AW'(0);
  localparam logic [AW-1:0] A_DPR  = AW'(1);
  localparam logic [AW-1:0] A_CMDR = AW'(2);

  localparam logic [7:0] C_WRITE = 8'h01;
  localparam logic [7:0] C_RACK  = 8'h02;
  localparam logic [7:0] C_RNAK  = 8'h03;
  localparam logic [7:0] C_START = 8'h04;
  localparam logic [7:0] C_STOP  = 8'h05;
  localparam logic [7:0] C_SBUS  = 8'h06;

  typedef enum logic [3:0] {
    S_INIT, S_IDLE, S_SETBUS, S_START, S_ADDR, S_WDATA,
    S_RDATA, S_RDPR, S_RPUSH, S_STOP, S_FINISH
  } state_t;

  // Sub-steps shared by every command state.
  typedef enum logic [2:0] {
    P_FETCH, P_DPR, P_CMD, P_IRQ, P_STS
  } phase_t;

  state_t state_q, state_d;
  phase_t phase_q, phase_d;

  logic                      cyc_q, cyc_d;
  logic                      we_q, we_d;
  logic [AW-1:0]             adr_q, adr_d;
  logic [DW-1:0]             wdat_q, wdat_d;
  logic [3:0]                bus_c_q, bus_c_d;
  logic                      bus_v_q, bus_v_d;
  logic [3:0]                rq_bus_q, rq_bus_d;
  logic [I2C_ADDR_WIDTH-1:0] rq_addr_q, rq_addr_d;
  logic                      rq_op_q, rq_op_d;
  logic [LW-1:0]             cnt_q, cnt_d;
  logic [7:0]                dbuf_q, dbuf_d;
  logic [7:0]                rdat_q, rdat_d;
  logic                      nak_q, nak_d;
  logic                      al_q, al_d;
  logic                      err_q, err_d;

  logic          acc_req;
  logic          acc_we;
  logic          acc_done;
  logic [AW-1:0] acc_adr;
  logic [DW-1:0] acc_dat;
  logic [DW-1:0] dpr_val;
  logic [DW-1:0] cmd_val;
  logic          cmd_st;
  logic          req_new_bus;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q   <= S_INIT;
      phase_q   <= P_CMD;
      cyc_q     <= 1'b0;
      we_q      <= 1'b0;
      adr_q     <= '0;
      wdat_q    <= '0;
      bus_c_q   <= '0;
      bus_v_q   <= 1'b0;
      rq_bus_q  <= '0;
      rq_addr_q <= '0;
      rq_op_q   <= 1'b0;
      cnt_q     <= '0;
      dbuf_q    <= '0;
      rdat_q    <= '0;
      nak_q     <= 1'b0;
      al_q      <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      phase_q   <= phase_d;
      cyc_q     <= cyc_d;
      we_q      <= we_d;
      adr_q     <= adr_d;
      wdat_q    <= wdat_d;
      bus_c_q   <= bus_c_d;
      bus_v_q   <= bus_v_d;
      rq_bus_q  <= rq_bus_d;
      rq_addr_q <= rq_addr_d;
      rq_op_q   <= rq_op_d;
      cnt_q     <= cnt_d;
      dbuf_q    <= dbuf_d;
      rdat_q    <= rdat_d;
      nak_q     <= nak_d;
      al_q      <= al_d;
      err_q     <= err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    phase_d   = phase_q;
    cyc_d     = cyc_q;
    we_d      = we_q;
    adr_d     = adr_q;
    wdat_d    = wdat_q;
    bus_c_d   = bus_c_q;
    bus_v_d   = bus_v_q;
    rq_bus_d  = rq_bus_q;
    rq_addr_d = rq_addr_q;
    rq_op_d   = rq_op_q;
    cnt_d     = cnt_q;
    dbuf_d    = dbuf_q;
    rdat_d    = rdat_q;
    nak_d     = nak_q;
    al_d      = al_q;
    err_d     = err_q;
    acc_req   = 1'b0;
    acc_we    = 1'b0;
    acc_adr   = '0;
    acc_dat   = '0;
    dpr_val   = '0;
    cmd_val   = '0;
    cmd_st    = 1'b0;
    acc_done  = cyc_q & io.ack_i;
    req_new_bus = !bus_v_q || (io.req_bus_i != bus_c_q);

    unique case (state_q)
      S_SETBUS: begin
        cmd_st  = 1'b1;
        dpr_val = DW'(rq_bus_q);
        cmd_val = DW'(C_SBUS);
      end
      S_START: begin
        cmd_st  = 1'b1;
        cmd_val = DW'(C_START);
      end
      S_ADDR: begin
        cmd_st  = 1'b1;
        dpr_val = DW'({rq_addr_q, rq_op_q});
        cmd_val = DW'(C_WRITE);
      end
      S_WDATA: begin
        cmd_st  = 1'b1;
        dpr_val = DW'(dbuf_q);
        cmd_val = DW'(C_WRITE);
      end
      S_RDATA: begin
        cmd_st  = 1'b1;
        // Last byte is NAKed so the slave releases SDA.
        cmd_val = (cnt_q == LW'(1)) ? DW'(C_RNAK) : DW'(C_RACK);
      end
      S_STOP: begin
        cmd_st  = 1'b1;
        cmd_val = DW'(C_STOP);
      end
      default: ;
    endcase

    if (state_q == S_INIT) begin
      acc_req = 1'b1;
      acc_we  = 1'b1;
      acc_adr = A_CSR;
      acc_dat = DW'(8'hC0);
    end else if (state_q == S_RDPR) begin
      acc_req = 1'b1;
      acc_adr = A_DPR;
    end else if (cmd_st) begin
      unique case (phase_q)
        P_DPR: begin
          acc_req = 1'b1;
          acc_we  = 1'b1;
          acc_adr = A_DPR;
          acc_dat = dpr_val;
        end
        P_CMD: begin
          acc_req = 1'b1;
          acc_we  = 1'b1;
          acc_adr = A_CMDR;
          acc_dat = cmd_val;
        end
        P_STS: begin
          acc_req = 1'b1;
          acc_adr = A_CMDR;
        end
        default: ;
      endcase
    end

    // Launch only from an idle bus so every access is
    // preceded by at least one cycle with cyc low.
    if (cyc_q) begin
      if (io.ack_i) begin
        cyc_d  = 1'b0;
        we_d   = 1'b0;
        adr_d  = '0;
        wdat_d = '0;
      end
    end else if (acc_req) begin
      cyc_d  = 1'b1;
      we_d   = acc_we;
      adr_d  = acc_adr;
      wdat_d = acc_dat;
    end

    unique case (state_q)
      S_INIT: begin
        bus_v_d = 1'b0;
        if (acc_done) state_d = S_IDLE;
      end
      S_IDLE: begin
        if (io.req_valid_i) begin
          rq_bus_d  = io.req_bus_i;
          rq_addr_d = io.req_addr_i;
          rq_op_d   = io.req_op_i;
          cnt_d     = io.req_len_i;
          nak_d     = 1'b0;
          al_d      = 1'b0;
          err_d     = 1'b0;
          state_d   = req_new_bus ? S_SETBUS : S_START;
          phase_d   = req_new_bus ? P_DPR : P_CMD;
        end
      end
      S_RDPR: begin
        if (acc_done) begin
          rdat_d  = io.dat_i[7:0];
          state_d = S_RPUSH;
        end
      end
      S_RPUSH: begin
        if (io.rdat_ready_i) begin
          if (cnt_q != '0) cnt_d = cnt_q - LW'(1);
          state_d = (cnt_q <= LW'(1)) ? S_STOP : S_RDATA;
          phase_d = P_CMD;
        end
      end
      S_FINISH: state_d = S_IDLE;
      default: begin
        unique case (phase_q)
          P_FETCH: begin
            if (io.wdat_valid_i) begin
              dbuf_d  = io.wdat_i;
              phase_d = P_DPR;
            end
          end
          P_DPR: if (acc_done) phase_d = P_CMD;
          P_CMD: if (acc_done) phase_d = P_IRQ;
          P_IRQ: if (io.irq_i) phase_d = P_STS;
          P_STS: begin
            if (acc_done) begin
              phase_d = P_CMD;
              if (io.dat_i[5]) begin
                // Lost arbitration: bus no longer ours, no STOP.
                al_d    = 1'b1;
                bus_v_d = 1'b0;
                state_d = S_FINISH;
              end else if (io.dat_i[4]) begin
                err_d   = 1'b1;
                bus_v_d = 1'b0;
                state_d = S_FINISH;
              end else if (io.dat_i[6]) begin
                nak_d   = 1'b1;
                state_d = (state_q == S_ADDR || state_q == S_WDATA) ?
                          S_STOP : S_FINISH;
              end else if (!io.dat_i[7]) begin
                err_d   = 1'b1;
                state_d = S_FINISH;
              end else begin
                unique case (state_q)
                  S_SETBUS: begin
                    bus_c_d = rq_bus_q;
                    bus_v_d = 1'b1;
                    state_d = S_START;
                  end
                  S_START: begin
                    state_d = S_ADDR;
                    phase_d = P_DPR;
                  end
                  S_ADDR: begin
                    if (cnt_q == '0) begin
                      state_d = S_STOP;
                    end else if (rq_op_q) begin
                      state_d = S_RDATA;
                    end else begin
                      state_d = S_WDATA;
                      phase_d = P_FETCH;
                    end
                  end
                  S_WDATA: begin
                    if (cnt_q != '0) cnt_d = cnt_q - LW'(1);
                    if (cnt_q <= LW'(1)) begin
                      state_d = S_STOP;
                    end else begin
                      phase_d = P_FETCH;
                    end
                  end
                  S_RDATA: state_d = S_RDPR;
                  default: state_d = S_FINISH;
                endcase
              end
            end
          end
          default: phase_d = P_CMD;
        endcase
      end
    endcase
  end

  assign io.cyc_o        = cyc_q;
  assign io.stb_o        = cyc_q;
  assign io.we_o         = we_q;
  assign io.adr_o        = adr_q;
  assign io.dat_o        = wdat_q;
  assign io.req_ready_o  = (state_q == S_IDLE);
  assign io.wdat_ready_o = (state_q == S_WDATA) && (phase_q == P_FETCH);
  assign io.rdat_valid_o = (state_q == S_RPUSH);
  assign io.rdat_o       = rdat_q;
  assign io.done_o       = (state_q == S_FINISH);
  assign io.nak_o        = nak_q;
  assign io.al_o         = al_q;
  assign io.err_o        = err_q;
endmodule
